// File: rtl/fib_sched.sv
// fib_sched: round-robin scheduler sharing one fib core between NUM_REQ requesters.
// The core polls a two-word mailbox (word 0 = start flag, word 1 = n) and reports
// its result through fib_wen/fib_data_o. Every job is guarded by a cycle timeout.
// When the timeout expires the job is answered with an error and the core is reset.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------------
//   RECOVER  | fib_rst held high while the recovery counter runs down
//   IDLE     | arbitrate requesters; req_ready is the one-hot grant
//   START    | start flag visible to the core for exactly one cycle
//   RUN      | wait for the core result write or for timer expiry
//   RESP     | result presented on resp_* until the consumer accepts it
module fib_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1000,
    parameter int RST_CYC = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_n,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [31:0]            resp_data,
    output logic                   resp_err,
    output logic                   fib_rst,
    input  logic [31:0]            fib_addr,
    output logic [31:0]            fib_data_i,
    input  logic                   fib_wen,
    input  logic [31:0]            fib_data_o
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CNT_W = $clog2(RST_CYC + 1);

    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RST_CYC);

    typedef enum logic [2:0] {
        ST_RECOVER,
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_RESP
    } state_t;

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] rst_cnt_q,    rst_cnt_d;
    logic [TMR_W-1:0] timer_q,      timer_d;
    logic [31:0]      n_q,          n_d;
    logic             start_q,      start_d;
    logic [ID_W-1:0]  rr_q,         rr_d;
    logic [ID_W-1:0]  id_q,         id_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q,  resp_data_d;
    logic             resp_err_q,   resp_err_d;
    logic             fib_rst_q,    fib_rst_d;

    logic [31:0]      req_n_a [NUM_REQ];
    logic             gnt_any;
    logic [ID_W-1:0]  gnt_idx;
    logic [ID_W:0]    scan;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_n_a[gi] = req_n[32*gi +: 32];
    end

    // Round-robin search: first valid requester at or above rr_q, wrapping to 0.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_q} + (ID_W+1)'(k);
            if (scan >= NUM_REQ_W) begin
                scan = scan - NUM_REQ_W;
            end
            if (!gnt_any && req_valid[scan[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[ID_W-1:0];
            end
        end
    end

    // Grant is only offered while idle, so at most one transfer per job.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_IDLE && gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Mailbox read port seen by the core: word 1 is n, everything else reads the start flag.
    assign fib_data_i = (fib_addr == 32'd1) ? n_q : {31'b0, start_q};

    // Next-state and next-output computation for the job sequencer.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        timer_d      = timer_q;
        n_d          = n_q;
        start_d      = 1'b0;
        rr_d         = rr_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        fib_rst_d    = fib_rst_q;

        case (state_q)
            ST_RECOVER: begin
                fib_rst_d = 1'b1;
                if (rst_cnt_q <= CNT_W'(1)) begin
                    state_d   = ST_IDLE;
                    fib_rst_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q - CNT_W'(1);
                end
            end

            ST_IDLE: begin
                if (gnt_any) begin
                    n_d     = req_n_a[gnt_idx];
                    id_d    = gnt_idx;
                    rr_d    = (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_W'(1);
                    start_d = 1'b1;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                timer_d = TMR_LOAD;
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // A result write on the expiry cycle still counts as success.
                if (fib_wen) begin
                    resp_data_d  = fib_data_o;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else if (timer_q == '0) begin
                    resp_data_d  = 32'd0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    if (resp_err_q) begin
                        state_d   = ST_RECOVER;
                        rst_cnt_d = CNT_LOAD;
                        fib_rst_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d   = ST_RECOVER;
                rst_cnt_d = CNT_LOAD;
                fib_rst_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset drops any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RECOVER;
            rst_cnt_q    <= CNT_LOAD;
            timer_q      <= '0;
            n_q          <= 32'd0;
            start_q      <= 1'b0;
            rr_q         <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= 1'b0;
            fib_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            timer_q      <= timer_d;
            n_q          <= n_d;
            start_q      <= start_d;
            rr_q         <= rr_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            fib_rst_q    <= fib_rst_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign fib_rst    = fib_rst_q;

endmodule

// File: tb/tb_fib_sched.sv
// tb_fib_sched: drives fib_sched with directed and random jobs against a
// transaction-level reference (round-robin pick, fib(n), timeout rule) and a
// behavioural fib core that polls the mailbox and answers after a set delay.
module tb_fib_sched;

    localparam int NR = 4;
    localparam int TO = 50;
    localparam int RC = 10;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [32*NR-1:0] req_n;
    logic [NR-1:0]   req_ready;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [31:0]     resp_data;
    logic            resp_err;
    logic            fib_rst;
    logic [31:0]     fib_addr;
    logic [31:0]     fib_data_i;
    logic            fib_wen;
    logic [31:0]     fib_data_o;

    fib_sched #(.NUM_REQ(NR), .ID_W(2), .TIMEOUT(TO), .RST_CYC(RC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_n      (req_n),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .fib_rst    (fib_rst),
        .fib_addr   (fib_addr),
        .fib_data_i (fib_data_i),
        .fib_wen    (fib_wen),
        .fib_data_o (fib_data_o)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ready_pulses = 0;
    int jobs = 0;
    int ptr = 0;
    int last_g = -1;
    logic [3:0]  pv;
    logic [31:0] pn [NR];

    // fib core model controls and observations
    int core_dly = 0;
    logic core_mute = 1'b0;
    int start_cyc = -1;
    int glitch = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fib(input logic [31:0] n);
        logic [31:0] a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < int'(n); i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (((v >> ((p + k) % NR)) & 4'b0001) != 4'b0000) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Grant counter: one req_ready pulse is expected per accepted job.
    initial forever begin
        @(negedge clk);
        #3;
        if (rst_n && req_ready != 0) ready_pulses++;
    end

    // Behavioural fib core: polls word 0, reads n from word 1, writes fib(n) after core_dly cycles.
    initial begin
        int cst;
        int dly;
        logic [31:0] core_n;
        cst = 0;
        dly = 0;
        core_n = 0;
        fib_addr = 0;
        fib_wen = 0;
        fib_data_o = 0;
        forever begin
            @(negedge clk);
            fib_wen = 1'b0;
            if (fib_rst || !rst_n) begin
                cst = 0;
                fib_addr = 0;
            end else begin
                case (cst)
                    0: if (fib_data_i == 32'd1) begin
                        start_cyc = cyc;
                        fib_addr = 1;
                        cst = 1;
                    end
                    1: begin
                        core_n = fib_data_i;
                        fib_addr = 0;
                        dly = core_dly;
                        cst = core_mute ? 0 : 2;
                    end
                    default: begin
                        if (fib_data_i != 0) glitch++;
                        if (dly == 0) begin
                            fib_wen = 1'b1;
                            fib_data_o = fib(core_n);
                            cst = 0;
                        end else begin
                            dly--;
                        end
                    end
                endcase
            end
        end
    end

    task automatic check_reset_vals();
        check_eq("rst_req_ready", 32'(req_ready), 0);
        check_eq("rst_resp_valid", 32'(resp_valid), 0);
        check_eq("rst_resp_id", 32'(resp_id), 0);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_resp_err", 32'(resp_err), 0);
        check_eq("rst_fib_rst", 32'(fib_rst), 1);
        check_eq("rst_fib_data_i", fib_data_i, 0);
    endtask

    task automatic count_rst(output int n);
        n = 0;
        while (fib_rst && n < 100) begin
            check_eq("no_resp_in_recover", 32'(resp_valid), 0);
            n++;
            step();
        end
    endtask

    task automatic do_reset();
        int n;
        rst_n = 1'b0;
        pv = 4'b0000;
        req_valid = '0;
        repeat (2) step();
        check_reset_vals();
        rst_n = 1'b1;
        count_rst(n);
        check_eq("rst_len", n, RC);
        ptr = 0;
    endtask

    task automatic wait_grant(output int g, output int gc);
        int t;
        int eg;
        req_valid = pv;
        req_n = {pn[3], pn[2], pn[1], pn[0]};
        #1;
        g = -1;
        gc = 0;
        t = 0;
        while (req_ready == 0 && t < 200) begin
            step();
            t++;
        end
        if (req_ready == 0) begin
            check_eq("grant_wait", 0, 1);
            return;
        end
        eg = pick(pv, ptr);
        check_eq("grant", 32'(req_ready), 32'd1 << eg);
        g = eg;
        last_g = eg;
        gc = cyc;
        ptr = (g + 1) % NR;
        jobs++;
        step();
        pv = pv & ~(4'b0001 << g);
        req_valid = pv;
    endtask

    task automatic get_resp(input int g, input logic [31:0] ed, input logic ee, input int ecyc, input int stall);
        int t;
        t = 0;
        while (!resp_valid && t < 400) begin
            step();
            t++;
        end
        if (!resp_valid) begin
            check_eq("resp_wait", 0, 1);
            return;
        end
        check_eq("resp_cyc", cyc, ecyc);
        check_eq("resp_id", 32'(resp_id), g);
        check_eq("resp_data", resp_data, ed);
        check_eq("resp_err", 32'(resp_err), 32'(ee));
        for (int i = 0; i < stall; i++) begin
            resp_ready = 1'b0;
            step();
            check_eq("hold_valid", 32'(resp_valid), 1);
            check_eq("hold_data", resp_data, ed);
            check_eq("hold_id", 32'(resp_id), g);
            check_eq("hold_req_ready", 32'(req_ready), 0);
        end
        resp_ready = 1'b1;
        step();
        check_eq("resp_drop", 32'(resp_valid), 0);
    endtask

    task automatic serve_one(input int stall);
        int g, gc, n_rst, ecyc;
        logic ee;
        logic [31:0] ed;
        wait_grant(g, gc);
        if (g < 0) return;
        ee = core_mute || (core_dly + 2 > TO);
        ed = ee ? 32'd0 : fib(pn[g]);
        ecyc = ee ? gc + TO + 2 : gc + core_dly + 4;
        get_resp(g, ed, ee, ecyc, stall);
        check_eq("start_cyc", start_cyc, gc + 1);
        if (ee) begin
            count_rst(n_rst);
            check_eq("abort_rst_len", n_rst, RC);
        end
    endtask

    initial begin
        int g, gc, n;
        rst_n = 1'b0;
        resp_ready = 1'b1;
        req_valid = '0;
        req_n = '0;
        pv = 4'b0000;
        for (int r = 0; r < NR; r++) pn[r] = 0;

        // reset values and recovery length
        do_reset();

        // single requester, n = 0..6
        for (int k = 0; k < 7; k++) begin
            pv[0] = 1'b1;
            pn[0] = k;
            core_dly = $urandom_range(0, 4);
            serve_one(0);
        end

        // all four requesters after reset, then requester 0 re-requests
        do_reset();
        pv = 4'b1111;
        pn[0] = 3; pn[1] = 4; pn[2] = 5; pn[3] = 6;
        core_dly = 1;
        serve_one(0);
        check_eq("order0", last_g, 0);
        pv[0] = 1'b1;
        pn[0] = 1;
        for (int k = 1; k <= 4; k++) begin
            serve_one(0);
            check_eq("order_rr", last_g, k % NR);
        end

        // core never answers: timeout, core reset, then a normal job
        core_mute = 1'b1;
        pv[2] = 1'b1; pn[2] = 7;
        serve_one(0);
        core_mute = 1'b0;
        core_dly = 3;
        pv[1] = 1'b1; pn[1] = 5;
        serve_one(0);

        // consumer stalls 20 cycles while another request waits
        pv[3] = 1'b1; pn[3] = 10;
        pv[0] = 1'b1; pn[0] = 12;
        core_dly = 2;
        serve_one(20);
        serve_one(0);

        // result write on the expiry cycle, and one cycle too late
        core_dly = TO - 2;
        pv[1] = 1'b1; pn[1] = 9;
        serve_one(0);
        core_dly = TO - 1;
        pv[2] = 1'b1; pn[2] = 4;
        serve_one(0);

        // reset during RUN: job dropped, fresh job afterwards
        core_dly = 20;
        pv[3] = 1'b1; pn[3] = 11;
        wait_grant(g, gc);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        step();
        step();
        rst_n = 1'b1;
        count_rst(n);
        check_eq("midjob_rst_len", n, RC);
        for (int k = 0; k < 30; k++) begin
            if (resp_valid) check_eq("stale_resp", 32'(resp_valid), 0);
            step();
        end
        ptr = 0;
        core_dly = 2;
        pv[2] = 1'b1; pn[2] = 6;
        serve_one(0);

        // random mix of requesters, n, core delay and consumer stalls
        for (int it = 0; it < 24; it++) begin
            for (int r = 0; r < NR; r++) begin
                if (!pv[r] && $urandom_range(0, 1) == 1) begin
                    pv[r] = 1'b1;
                    pn[r] = $urandom_range(0, 30);
                end
            end
            if (pv == 4'b0000) begin
                pv[0] = 1'b1;
                pn[0] = $urandom_range(0, 30);
            end
            core_dly = (it % 6 == 5) ? int'($urandom_range(TO - 4, TO + 1)) : int'($urandom_range(0, 6));
            serve_one(int'($urandom_range(0, 3)));
        end

        check_eq("ready_pulses", ready_pulses, jobs);
        check_eq("start_flag_glitch", glitch, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fib_sched.md
Name: fib_sched

Overview:
- Round-robin job scheduler that shares one fib core between NUM_REQ requesters.
- Accepts an index n from a requester and serves the core's two-word mailbox: word 0 is the start flag, word 1 is n.
- Captures the core's result write and returns it tagged with the requester id.
- Guards every job with a cycle timeout; on expiry it resets the core.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 2, width of resp_id; must satisfy 2**ID_W >= NUM_REQ
TIMEOUT, 1000, cycles allowed in RUN before a job is aborted
RST_CYC, 10, cycles fib_rst_o is held high after reset or abort

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester job request
req_n  in  32*NUM_REQ  packed n values; requester i uses bits [32i+31:32i]
req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when valid&ready
resp_valid  out  1  result available
resp_ready  in  1  result consumer ready
resp_id  out  ID_W  requester index of the result
resp_data  out  32  fib(n) result (0 on error)
resp_err  out  1  job timed out
fib_rst  out  1  active-high reset to the fib core
fib_addr  in  32  core mailbox address
fib_data_i  out  32  mailbox read data to the core
fib_wen  in  1  core result write strobe
fib_data_o  in  32  core result data

Behaviour:
- States: RECOVER, IDLE, START, RUN, RESP.
- Async reset values:
  - state=RECOVER, rst counter=RST_CYC, fib_rst=1.
  - req_ready=0; resp_valid=0, resp_id=0, resp_data=0, resp_err=0.
  - n_reg=0, start_word=0, rr pointer=0.
- RECOVER:
  - fib_rst=1; counter decrements each cycle.
  - When counter reaches 1, next state is IDLE and fib_rst drops.
  - fib_rst is high for exactly RST_CYC cycles.
- IDLE:
  - req_ready is combinational and one-hot: the first asserted req_valid found searching upward from the rr pointer, with wrap.
  - On grant g: latch n_reg=req_n[g] and id=g; rr pointer=(g+1) mod NUM_REQ; next state START.
  - No request: stay in IDLE, req_ready=0.
  - req_ready is 0 in every other state.
- START:
  - start_word=1 for exactly this one cycle; next state RUN.
  - Timer loaded with TIMEOUT-1.
- RUN:
  - start_word=0.
  - If fib_wen: resp_data=fib_data_o, resp_err=0, next state RESP.
  - Else if timer==0: resp_data=0, resp_err=1, next state RESP.
  - Else timer decrements.
  - If fib_wen and timer==0 occur in the same cycle, fib_wen wins (no error).
- Mailbox read, combinational:
  - fib_data_i = n_reg when fib_addr==1.
  - fib_data_i = {31'b0,start_word} for any other address.
- fib_wen is ignored outside RUN.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err are held stable until resp_valid&resp_ready.
  - After the handshake: next state RECOVER (counter=RST_CYC) if resp_err, else IDLE.
  - resp_valid drops the cycle after the handshake.
- Latency for a non-timeout job:
  - grant cycle → START +1 → RUN +2.
  - resp_valid asserts the cycle after the fib_wen sample.
- Reset asserted mid-job: the job is dropped silently; no response is produced.
- Requesters must hold req_valid and req_n stable until accepted.

Test Plan:
- Single requester 0 with n=0..6 in sequence, resp_ready=1 → resp_data 0,1,1,2,3,5,8; resp_id=0; resp_err=0; req_ready pulses once per job.
- All four requesters hold valid after reset with n=3,4,5,6 → grants in order 0,1,2,3; resp_id order 0,1,2,3; data 2,3,5,8. Requester 0 then re-requests n=1 → granted only after 1,2,3.
- Core model that never writes, TIMEOUT=50 → resp_valid with resp_err=1, resp_data=0 exactly 50 RUN cycles after START; fib_rst=1 for 10 cycles after the response handshake; next job n=5 returns 5.
- resp_ready held low 20 cycles with a result pending → resp_valid and resp_data stable throughout; req_ready stays 0; transfer completes on the first resp_ready cycle.
- rst_n pulsed low during RUN → all outputs at reset values immediately; fib_rst high for 10 cycles after release; no stale response; a fresh n=6 job returns 8.
- fib_wen forced on the cycle the timer hits 0 → resp_err=0 and resp_data = core data.
